// File: rtl/pipeline2_sub_if.sv
// rtl/pipeline2_sub_if.sv - operand/result handshake bundle for pipeline2_sub
interface pipeline2_sub_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        bout;
    logic        ovf;

    // Producer/consumer side: drives operands and out_ready, observes results
    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );

    // Subtractor side
    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );
endinterface

// File: rtl/pipeline2_sub.sv
// rtl/pipeline2_sub.sv - two-stage 32-bit subtractor with valid/ready, optional PIPE_SUB_OVF_EN overflow flag
module pipeline2_sub (
    input  logic              clk,
    input  logic              rst_n,
    pipeline2_sub_if.slave    bus
);

    // Stage 1 state: resolved low half plus the raw high operands
    logic        s1_valid;
    logic [15:0] lo_diff;
    logic        c_mid;
    logic [15:0] hi_a;
    logic [15:0] hi_b;

    // Stage 2 (output) state
    logic        out_valid_q;
    logic [31:0] diff_q;
    logic        bout_q;

    logic        s1_accept;
    logic        s2_advance;
    logic [16:0] lo_sum;
    logic [16:0] hi_sum;

    // Subtraction as a + ~b + ~bin; the carry out of each half is the inverted borrow
    assign lo_sum = {1'b0, bus.a[15:0]} + {1'b0, ~bus.b[15:0]} + {16'd0, ~bus.bin};
    assign hi_sum = {1'b0, hi_a} + {1'b0, ~hi_b} + {16'd0, c_mid};

    assign s2_advance   = s1_valid && (!out_valid_q || bus.out_ready);
    assign bus.in_ready = !s1_valid || s2_advance;
    assign s1_accept    = bus.in_valid && bus.in_ready;

    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;

    // Stage 1 valid: set on accept, cleared when its data moves on with nothing behind it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (s1_accept) begin
            s1_valid <= 1'b1;
        end else if (s2_advance) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 1 data: loads only on accept so a stalled entry stays intact
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_diff <= 16'd0;
            c_mid   <= 1'b0;
            hi_a    <= 16'd0;
            hi_b    <= 16'd0;
        end else if (s1_accept) begin
            lo_diff <= lo_sum[15:0];
            c_mid   <= lo_sum[16];
            hi_a    <= bus.a[31:16];
            hi_b    <= bus.b[31:16];
        end
    end

    // Stage 2 valid: set on advance, cleared when a result is consumed with no successor
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
        end else if (s2_advance) begin
            out_valid_q <= 1'b1;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Stage 2 data: high half resolved here; held bit-stable while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q <= 32'd0;
            bout_q <= 1'b0;
        end else if (s2_advance) begin
            diff_q <= {hi_sum[15:0], lo_diff};
            bout_q <= ~hi_sum[16];
        end
    end

`ifdef PIPE_SUB_OVF_EN
    logic ovf_q;

    // Signed overflow: operands of differing sign and a result whose sign departs from the minuend
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (s2_advance) begin
            ovf_q <= (hi_a[15] != hi_b[15]) && (hi_sum[15] != hi_a[15]);
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

endmodule
